scr1_dmem_arbiter: RTL and testbench

Two-master arbiter sharing one SCR1 data-memory port between the core data path (M0) and a secondary master (M1, e.g. DMA or crypto accelerator). Supports the pipelined SCR1 memif protocol:
- address phase: req/req_ack;
- data phase: resp/rdata;
- back-to-back accepts when resp is RDY_OK.
Sits between the requesters and the dmem router/TCM port. Provides selectable round-robin or fixed priority with starvation protection.

---
 rtl/scr1_dmem_arbiter_pkg.sv | 36 +++
 rtl/scr1_dmem_arbiter_if.sv | 22 ++
 rtl/scr1_dmem_arbiter_picker.sv | 77 +++++++
 rtl/scr1_dmem_arbiter.sv | 103 ++++++++++
 tb/tb_scr1_dmem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_dmem_arbiter_pkg.sv
// Shared types and constants for the two-master SCR1 dmem arbiter.
package scr1_arb_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;
  localparam int SCR1_ARB_CNT_W   = 8;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    ARB_ADDR = 1'b0,
    ARB_DATA = 1'b1
  } type_scr1_arb_fsm_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } type_scr1_arb_mst_e;

endpackage

// File: rtl/scr1_dmem_arbiter_if.sv
// SCR1 dmem memif bundle: address phase req/req_ack, data phase resp/rdata.
interface scr1_dmem_arbiter_if;
  import scr1_arb_pkg::*;

  logic                        req;
  logic                        req_ack;
  type_scr1_mem_cmd_e          cmd;
  type_scr1_mem_width_e        width;
  logic [SCR1_DMEM_AWIDTH-1:0] addr;
  logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata;
  type_scr1_mem_resp_e         resp;

  // Requester side drives the address phase and receives the data phase.
  modport master (output req, cmd, width, addr, wdata,
                  input  req_ack, rdata, resp);

  // Responder side accepts the address phase and returns the data phase.
  modport slave  (input  req, cmd, width, addr, wdata,
                  output req_ack, rdata, resp);

endinterface

// File: rtl/scr1_dmem_arbiter_picker.sv
// Grant selection for the dmem arbiter: round-robin or fixed priority with an
// M1 starvation counter, plus a lock that pins the grant until the slave accepts.
module scr1_arb_picker import scr1_arb_pkg::*; #(
  parameter bit SCR1_ARB_RR_EN    = 1'b1,
  parameter int SCR1_ARB_MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slot_open,
  input  logic               m0_req,
  input  logic               m1_req,
  input  logic               s_req_ack,
  output type_scr1_arb_mst_e grant,
  output logic               s_req
);

  localparam logic [SCR1_ARB_CNT_W-1:0] MAX_WAIT_C = SCR1_ARB_CNT_W'(SCR1_ARB_MAX_WAIT);

  type_scr1_arb_mst_e        last_gnt_r;
  type_scr1_arb_mst_e        lock_mst_r;
  logic                      lock_r;
  logic [SCR1_ARB_CNT_W-1:0] wait_cnt;
  logic                      gnt_req;
  logic                      accept;

  // Pick the winner; a pending unaccepted request keeps its grant.
  always_comb begin
    grant = ARB_M0;
    if (lock_r) begin
      grant = lock_mst_r;
    end else if (m0_req && !m1_req) begin
      grant = ARB_M0;
    end else if (m1_req && !m0_req) begin
      grant = ARB_M1;
    end else if (m0_req && m1_req) begin
      if (SCR1_ARB_RR_EN) begin
        grant = (last_gnt_r == ARB_M0) ? ARB_M1 : ARB_M0;
      end else begin
        grant = (wait_cnt == MAX_WAIT_C) ? ARB_M1 : ARB_M0;
      end
    end
  end

  // Reset gating keeps the slave request low while rst_n is held.
  assign gnt_req = (grant == ARB_M1) ? m1_req : m0_req;
  assign s_req   = gnt_req & slot_open & rst_n;
  assign accept  = s_req & s_req_ack;

  // Lock tracks a stalled address phase; last grant drives round-robin fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r     <= 1'b0;
      lock_mst_r <= ARB_M0;
      last_gnt_r <= ARB_M1;
    end else begin
      if (slot_open) begin
        lock_r <= s_req & ~s_req_ack;
        if (s_req && !s_req_ack) lock_mst_r <= grant;
      end
      if (accept) last_gnt_r <= grant;
    end
  end

  // Count cycles M1 has been kept waiting, saturating at the forced-grant threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (SCR1_ARB_RR_EN || !m1_req) begin
      wait_cnt <= '0;
    end else if (accept && (grant == ARB_M1)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scr1_dmem_arbiter.sv
// Two-master arbiter in front of one SCR1 dmem port. Address phases are muxed
// from the granted master; data phases are routed back to the recorded owner.
//
// state    | meaning
// ARB_ADDR | no transaction outstanding, slot open for a new accept
// ARB_DATA | one accepted transaction awaiting its response
module scr1_dmem_arbiter import scr1_arb_pkg::*; #(
  parameter bit SCR1_ARB_RR_EN    = 1'b1,
  parameter int SCR1_ARB_MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  scr1_dmem_arbiter_if.slave  m0,
  scr1_dmem_arbiter_if.slave  m1,
  scr1_dmem_arbiter_if.master s
);

  type_scr1_arb_fsm_e fsm_r, fsm_next;
  type_scr1_arb_mst_e owner_r, owner_next;
  type_scr1_arb_mst_e grant;
  logic               slot_open;
  logic               s_req_int;
  logic               accept;
  logic               data_vld;

  // A new address phase may go out when idle, or overlap a successful response.
  assign slot_open = (fsm_r == ARB_ADDR) ||
                     ((fsm_r == ARB_DATA) && (s.resp == SCR1_MEM_RESP_RDY_OK));

  scr1_arb_picker #(
    .SCR1_ARB_RR_EN    (SCR1_ARB_RR_EN),
    .SCR1_ARB_MAX_WAIT (SCR1_ARB_MAX_WAIT)
  ) u_picker (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_open (slot_open),
    .m0_req    (m0.req),
    .m1_req    (m1.req),
    .s_req_ack (s.req_ack),
    .grant     (grant),
    .s_req     (s_req_int)
  );

  assign accept = s_req_int & s.req_ack;

  // Next state and next owner; an error response always closes the pipeline.
  always_comb begin
    fsm_next   = fsm_r;
    owner_next = owner_r;
    case (fsm_r)
      ARB_ADDR: begin
        if (accept) begin
          fsm_next   = ARB_DATA;
          owner_next = grant;
        end
      end
      ARB_DATA: begin
        case (s.resp)
          SCR1_MEM_RESP_RDY_OK: begin
            if (accept) owner_next = grant;
            else        fsm_next   = ARB_ADDR;
          end
          SCR1_MEM_RESP_RDY_ER: fsm_next = ARB_ADDR;
          default: ;
        endcase
      end
      default: fsm_next = ARB_ADDR;
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r   <= ARB_ADDR;
      owner_r <= ARB_M0;
    end else begin
      fsm_r   <= fsm_next;
      owner_r <= owner_next;
    end
  end

  assign s.req   = s_req_int;
  assign s.cmd   = (grant == ARB_M1) ? m1.cmd   : m0.cmd;
  assign s.width = (grant == ARB_M1) ? m1.width : m0.width;
  assign s.addr  = (grant == ARB_M1) ? m1.addr  : m0.addr;
  assign s.wdata = (grant == ARB_M1) ? m1.wdata : m0.wdata;

  assign m0.req_ack = accept & (grant == ARB_M0);
  assign m1.req_ack = accept & (grant == ARB_M1);

  // The response always belongs to the owner recorded at accept time.
  assign data_vld = (fsm_r == ARB_DATA);
  assign m0.resp  = (data_vld && owner_r == ARB_M0) ? s.resp  : SCR1_MEM_RESP_IDLE;
  assign m1.resp  = (data_vld && owner_r == ARB_M1) ? s.resp  : SCR1_MEM_RESP_IDLE;
  assign m0.rdata = (data_vld && owner_r == ARB_M0) ? s.rdata : '0;
  assign m1.rdata = (data_vld && owner_r == ARB_M1) ? s.rdata : '0;

`ifndef SYNTHESIS
  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n)
                              !(m0.req_ack && m1.req_ack));
`endif

endmodule

// File: tb/tb_scr1_dmem_arbiter.sv
// Bench for scr1_dmem_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority with MAX_WAIT = 4. Both see identical stimulus.
module tb_scr1_dmem_arbiter;
  import scr1_arb_pkg::*;

  localparam int MAXW_FX = 4;
  localparam logic [31:0] A0 = 32'h0001_0010;
  localparam logic [31:0] A1 = 32'h0002_0020;
  localparam type_scr1_mem_resp_e RI = SCR1_MEM_RESP_IDLE;
  localparam type_scr1_mem_resp_e RO = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e RE = SCR1_MEM_RESP_RDY_ER;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 m0_req, m1_req, s_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
  type_scr1_mem_width_e m0_width, m1_width;
  logic [31:0]          m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  type_scr1_mem_resp_e  s_resp;

  logic        o_sreq [2];
  logic        o_m0ack [2];
  logic        o_m1ack [2];
  logic        o_scmd [2];
  logic [1:0]  o_swidth [2];
  logic [1:0]  o_m0resp [2];
  logic [1:0]  o_m1resp [2];
  logic [31:0] o_saddr [2];
  logic [31:0] o_swdata [2];
  logic [31:0] o_m0rdata [2];
  logic [31:0] o_m1rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scr1_dmem_arbiter_if i_m0 ();
    scr1_dmem_arbiter_if i_m1 ();
    scr1_dmem_arbiter_if i_s ();

    assign i_m0.req   = m0_req;
    assign i_m0.cmd   = m0_cmd;
    assign i_m0.width = m0_width;
    assign i_m0.addr  = m0_addr;
    assign i_m0.wdata = m0_wdata;
    assign i_m1.req   = m1_req;
    assign i_m1.cmd   = m1_cmd;
    assign i_m1.width = m1_width;
    assign i_m1.addr  = m1_addr;
    assign i_m1.wdata = m1_wdata;
    assign i_s.req_ack = s_ack;
    assign i_s.rdata   = s_rdata;
    assign i_s.resp    = s_resp;

    scr1_dmem_arbiter #(
      .SCR1_ARB_RR_EN    (g == 0),
      .SCR1_ARB_MAX_WAIT (g == 0 ? 8 : MAXW_FX)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (i_m0),
      .m1    (i_m1),
      .s     (i_s)
    );

    assign o_sreq[g]    = i_s.req;
    assign o_scmd[g]    = i_s.cmd;
    assign o_swidth[g]  = i_s.width;
    assign o_saddr[g]   = i_s.addr;
    assign o_swdata[g]  = i_s.wdata;
    assign o_m0ack[g]   = i_m0.req_ack;
    assign o_m1ack[g]   = i_m1.req_ack;
    assign o_m0resp[g]  = i_m0.resp;
    assign o_m1resp[g]  = i_m1.resp;
    assign o_m0rdata[g] = i_m0.rdata;
    assign o_m1rdata[g] = i_m1.rdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each instance has a list of issued-but-unanswered
  // transactions (by issuer), a pinned master while an address phase stalls,
  // the last winner and how long M1 has been left waiting.
  int pend_q [2][$];
  bit pin_v [2];
  int pin_m [2];
  int last_w [2];
  int starve [2];

  function automatic void mdl_reset();
    for (int d = 0; d < 2; d++) begin
      pend_q[d].delete();
      pin_v[d]  = 1'b0;
      pin_m[d]  = 0;
      last_w[d] = 1;
      starve[d] = 0;
    end
  endfunction

  function automatic int mdl_grant(int d, bit r0, bit r1);
    if (pin_v[d]) return pin_m[d];
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return 0;
    if (d == 0) return 1 - last_w[d];
    return (starve[d] == MAXW_FX) ? 1 : 0;
  endfunction

  task automatic drive_idle();
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    s_resp = RI; s_rdata = '0;
    m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
    m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = A0; m1_addr = A1;
    m0_wdata = 32'h0000_00A0; m1_wdata = 32'h0000_00A1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mdl_reset();
  endtask

  typedef struct {
    logic r0, r1, ack;
    type_scr1_mem_resp_e rsp;
    logic [31:0] rd;
    logic e_sreq;
    logic [31:0] e_addr;
    logic e_a0, e_a1;
    type_scr1_mem_resp_e e_p0, e_p1;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // RR alternation, responses to issuer only, then a 3-cycle stalled M0 address phase.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, RI, 32'h0,         1'b1, A0, 1'b1, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, RO, 32'hA5A5_0000, 1'b1, A1, 1'b0, 1'b1, RO, RI, 32'hA5A5_0000, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, RO, 32'h5A5A_0001, 1'b1, A0, 1'b1, 1'b0, RI, RO, 32'h0, 32'h5A5A_0001};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, RO, 32'h1111_2222, 1'b1, A1, 1'b0, 1'b1, RO, RI, 32'h1111_2222, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, RO, 32'h3333_4444, 1'b0, 32'h0, 1'b0, 1'b0, RI, RO, 32'h0, 32'h3333_4444};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, RI, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, RI, 32'h0,         1'b1, A0, 1'b1, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, RO, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0, RO, RI, 32'h0000_0077, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, RI, 32'h0,         1'b1, A0, 1'b0, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, RI, 32'h0,         1'b1, A0, 1'b0, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, RI, 32'h0,         1'b1, A0, 1'b0, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, RI, 32'h0,         1'b1, A0, 1'b1, 1'b0, RI, RI, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, RO, 32'h0000_0088, 1'b1, A1, 1'b0, 1'b1, RO, RI, 32'h0000_0088, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, RO, 32'h0000_0099, 1'b0, 32'h0, 1'b0, 1'b0, RI, RO, 32'h0, 32'h0000_0099};

    // Reset values while requests and a response are being presented.
    drive_idle();
    m0_req = 1'b1; m1_req = 1'b1; s_ack = 1'b1; s_resp = RO; s_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.sreq[%0d]", d), o_sreq[d], 1'b0);
      chk($sformatf("rst.a0[%0d]", d), o_m0ack[d], 1'b0);
      chk($sformatf("rst.a1[%0d]", d), o_m1ack[d], 1'b0);
      chk($sformatf("rst.p0[%0d]", d), o_m0resp[d], RI);
      chk($sformatf("rst.p1[%0d]", d), o_m1resp[d], RI);
      chk($sformatf("rst.d0[%0d]", d), o_m0rdata[d], 32'h0);
      chk($sformatf("rst.d1[%0d]", d), o_m1rdata[d], 32'h0);
    end

    // Table vectors on the round-robin instance.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1; s_ack = tbl[i].ack;
      s_resp = tbl[i].rsp; s_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("tbl%0d.sreq", i), o_sreq[0], tbl[i].e_sreq);
      if (tbl[i].e_sreq) chk($sformatf("tbl%0d.saddr", i), o_saddr[0], tbl[i].e_addr);
      chk($sformatf("tbl%0d.a0", i), o_m0ack[0], tbl[i].e_a0);
      chk($sformatf("tbl%0d.a1", i), o_m1ack[0], tbl[i].e_a1);
      chk($sformatf("tbl%0d.p0", i), o_m0resp[0], tbl[i].e_p0);
      chk($sformatf("tbl%0d.p1", i), o_m1resp[0], tbl[i].e_p1);
      chk($sformatf("tbl%0d.d0", i), o_m0rdata[0], tbl[i].e_d0);
      chk($sformatf("tbl%0d.d1", i), o_m1rdata[0], tbl[i].e_d1);
      tick();
    end

    // Fixed priority: M1 forced through on its 5th waiting cycle, then again 5 later.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; s_ack = 1'b1; s_resp = RO;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve%0d.a0", k), o_m0ack[1], (k != 5 && k != 10));
      chk($sformatf("starve%0d.a1", k), o_m1ack[1], (k == 5 || k == 10));
      tick();
    end

    // Error response to M1 closes the slot for one cycle.
    do_reset();
    m1_req = 1'b1; s_ack = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("er.acc1[%0d]", d), o_m1ack[d], 1'b1);
    tick();
    m1_req = 1'b0; m0_req = 1'b1; s_resp = RE;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("er.p1[%0d]", d), o_m1resp[d], RE);
      chk($sformatf("er.a0[%0d]", d), o_m0ack[d], 1'b0);
      chk($sformatf("er.sreq[%0d]", d), o_sreq[d], 1'b0);
      chk($sformatf("er.p0[%0d]", d), o_m0resp[d], RI);
    end
    tick();
    s_resp = RI;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("er.next.a0[%0d]", d), o_m0ack[d], 1'b1);
      chk($sformatf("er.next.p1[%0d]", d), o_m1resp[d], RI);
    end
    tick();

    // Reset while a response is outstanding.
    do_reset();
    m0_req = 1'b1; s_ack = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("rm.acc0[%0d]", d), o_m0ack[d], 1'b1);
    tick();
    m0_req = 1'b0; s_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; s_ack = 1'b1; s_resp = RO; s_rdata = 32'hDEAD_BEEF;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rm.sreq[%0d]", d), o_sreq[d], 1'b0);
      chk($sformatf("rm.p0[%0d]", d), o_m0resp[d], RI);
      chk($sformatf("rm.p1[%0d]", d), o_m1resp[d], RI);
      chk($sformatf("rm.d0[%0d]", d), o_m0rdata[d], 32'h0);
    end
    rst_n = 1'b1;
    s_resp = RI;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rm.tie.a0[%0d]", d), o_m0ack[d], 1'b1);
      chk($sformatf("rm.tie.a1[%0d]", d), o_m1ack[d], 1'b0);
    end
    tick();

    // M1 alone: 10 back-to-back reads, no bubbles.
    do_reset();
    m1_req = 1'b1; s_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_resp  = (k == 0) ? RI : RO;
      s_rdata = 32'h100 + k;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("b2b%0d.a1[%0d]", k, d), o_m1ack[d], 1'b1);
        chk($sformatf("b2b%0d.p0[%0d]", k, d), o_m0resp[d], RI);
        if (k > 0) begin
          chk($sformatf("b2b%0d.p1[%0d]", k, d), o_m1resp[d], RO);
          chk($sformatf("b2b%0d.d1[%0d]", k, d), o_m1rdata[d], 32'h100 + k);
        end
      end
      tick();
    end
    m1_req = 1'b0; s_resp = RO; s_rdata = 32'h10A;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("b2b.last.p1[%0d]", d), o_m1resp[d], RO);
      chk($sformatf("b2b.last.d1[%0d]", d), o_m1rdata[d], 32'h10A);
      chk($sformatf("b2b.last.p0[%0d]", d), o_m0resp[d], RI);
    end
    tick();

    // Randomized traffic against the reference model, both instances.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int r;
      m0_req   = ($urandom_range(0, 99) < 60);
      m1_req   = ($urandom_range(0, 99) < 60);
      s_ack    = ($urandom_range(0, 99) < 65);
      m0_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      m1_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      m0_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      m1_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      m0_addr  = $urandom; m1_addr  = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      s_rdata  = $urandom;
      r = $urandom_range(0, 9);
      s_resp = (r < 4) ? RI : ((r < 9) ? RO : RE);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit open, e_sreq, acc;
        int g, own;
        open   = (pend_q[d].size() == 0) || (s_resp == RO);
        g      = mdl_grant(d, m0_req, m1_req);
        e_sreq = open && ((g == 0) ? m0_req : m1_req);
        acc    = e_sreq && s_ack;
        own    = (pend_q[d].size() != 0) ? pend_q[d][0] : -1;
        chk($sformatf("rnd%0d.sreq[%0d]", n, d), o_sreq[d], e_sreq);
        if (e_sreq) begin
          chk($sformatf("rnd%0d.saddr[%0d]", n, d), o_saddr[d], (g == 0) ? m0_addr : m1_addr);
          chk($sformatf("rnd%0d.swdata[%0d]", n, d), o_swdata[d], (g == 0) ? m0_wdata : m1_wdata);
          chk($sformatf("rnd%0d.scmd[%0d]", n, d), o_scmd[d], (g == 0) ? m0_cmd : m1_cmd);
          chk($sformatf("rnd%0d.swidth[%0d]", n, d), o_swidth[d], (g == 0) ? m0_width : m1_width);
        end
        chk($sformatf("rnd%0d.a0[%0d]", n, d), o_m0ack[d], acc && (g == 0));
        chk($sformatf("rnd%0d.a1[%0d]", n, d), o_m1ack[d], acc && (g == 1));
        chk($sformatf("rnd%0d.p0[%0d]", n, d), o_m0resp[d], (own == 0) ? s_resp : RI);
        chk($sformatf("rnd%0d.p1[%0d]", n, d), o_m1resp[d], (own == 1) ? s_resp : RI);
        chk($sformatf("rnd%0d.d0[%0d]", n, d), o_m0rdata[d], (own == 0) ? s_rdata : 32'h0);
        chk($sformatf("rnd%0d.d1[%0d]", n, d), o_m1rdata[d], (own == 1) ? s_rdata : 32'h0);
        if (own >= 0 && s_resp != RI) void'(pend_q[d].pop_front());
        if (acc) pend_q[d].push_back(g);
        if (open) begin
          pin_v[d] = e_sreq && !s_ack;
          if (pin_v[d]) pin_m[d] = g;
        end
        if (acc) last_w[d] = g;
        if (d == 1) begin
          if (!m1_req)              starve[d] = 0;
          else if (acc && g == 1)   starve[d] = 0;
          else if (starve[d] < MAXW_FX) starve[d] = starve[d] + 1;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
